tx_slot_sequencer: RTL and testbench

- Controller for the 2-bit encoder slot mux. The mux has three data slots (select 00/01/10) and an idle select (11) that forces the output to 0.
- Accepts 6-bit Tx words over a valid/ready handshake and holds each word stable on the mux data inputs.
- Steps the {sB, sA} selects through slots 0, 1, 2, holding each slot for HOLD_CYCLES clocks.
- Double-buffered, so back-to-back words stream with no idle gap.

---
 rtl/tx_slot_sequencer.sv | 134 +++++++++++++
 tb/tb_tx_slot_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_slot_sequencer.sv
// rtl/tx_slot_sequencer.sv - double-buffered slot sequencer for the 2-bit encoder slot mux
module tx_slot_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter int NUM_SLOTS   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [5:0] i_tx_data,
  output logic       o_tx_ready,
  input  logic       i_abort,
  output logic [5:0] o_word_out,
  output logic       o_sb,
  output logic       o_sa,
  output logic       o_sym_valid,
  output logic       o_frame_start,
  output logic       o_busy
);

  localparam int             CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]     LAST_SLOT = 2'(NUM_SLOTS - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t        r_state, w_nxt_state;
  logic [5:0]    r_active, w_nxt_active;
  logic [5:0]    r_shadow, w_nxt_shadow;
  logic          r_active_full, w_nxt_active_full;
  logic          r_shadow_full, w_nxt_shadow_full;
  logic [1:0]    r_slot, w_nxt_slot;
  logic [CW-1:0] r_hold, w_nxt_hold;
  logic          r_frame_start, w_nxt_frame_start;

  logic          w_accept;
  logic          w_slot_end;
  logic          w_frame_end;
  logic [1:0]    w_sel;

  assign o_tx_ready  = !r_shadow_full && !i_abort;
  assign w_accept    = i_tx_valid && o_tx_ready;
  assign w_slot_end  = (r_state == ST_SEND) && (r_hold == HOLD_LAST);
  assign w_frame_end = w_slot_end && (r_slot == LAST_SLOT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_active      <= '0;
      r_shadow      <= '0;
      r_active_full <= 1'b0;
      r_shadow_full <= 1'b0;
      r_slot        <= '0;
      r_hold        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_active      <= w_nxt_active;
      r_shadow      <= w_nxt_shadow;
      r_active_full <= w_nxt_active_full;
      r_shadow_full <= w_nxt_shadow_full;
      r_slot        <= w_nxt_slot;
      r_hold        <= w_nxt_hold;
      r_frame_start <= w_nxt_frame_start;
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_active      = r_active;
    w_nxt_shadow      = r_shadow;
    w_nxt_active_full = r_active_full;
    w_nxt_shadow_full = r_shadow_full;
    w_nxt_slot        = r_slot;
    w_nxt_hold        = r_hold;
    w_nxt_frame_start = 1'b0;

    if (i_abort) begin
      // Flush wins over both acceptance and frame end; active data is kept only as the held word_out value.
      w_nxt_state       = ST_IDLE;
      w_nxt_active_full = 1'b0;
      w_nxt_shadow_full = 1'b0;
      w_nxt_slot        = '0;
      w_nxt_hold        = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_nxt_state       = ST_SEND;
            w_nxt_active      = i_tx_data;
            w_nxt_active_full = 1'b1;
            w_nxt_slot        = '0;
            w_nxt_hold        = '0;
            w_nxt_frame_start = 1'b1;
          end
        end
        ST_SEND: begin
          w_nxt_hold = w_slot_end ? '0 : r_hold + CW'(1);
          if (w_frame_end) begin
            w_nxt_slot = '0;
            if (r_shadow_full) begin
              w_nxt_active      = r_shadow;
              w_nxt_shadow_full = 1'b0;
              w_nxt_frame_start = 1'b1;
            end else if (w_accept) begin
              w_nxt_active      = i_tx_data;
              w_nxt_frame_start = 1'b1;
            end else begin
              w_nxt_state       = ST_IDLE;
              w_nxt_active_full = 1'b0;
            end
          end else begin
            if (w_slot_end) begin
              w_nxt_slot = r_slot + 2'd1;
            end
            if (w_accept) begin
              w_nxt_shadow      = i_tx_data;
              w_nxt_shadow_full = 1'b1;
            end
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  assign w_sel         = (r_state == ST_SEND) ? r_slot : 2'b11;
  assign o_sb          = w_sel[1];
  assign o_sa          = w_sel[0];
  assign o_sym_valid   = (r_state == ST_SEND);
  assign o_frame_start = r_frame_start;
  assign o_word_out    = r_active;
  assign o_busy        = r_active_full || r_shadow_full;

endmodule

// File: tb/tb_tx_slot_sequencer.sv
// tb/tb_tx_slot_sequencer.sv - scoreboard bench for tx_slot_sequencer at HOLD_CYCLES 1 and 4
module tb_tx_slot_sequencer;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      tx_valid;
  logic [1:0][5:0] tx_data;
  logic [1:0]      abort;
  logic [1:0]      tx_ready;
  logic [1:0][5:0] word_out;
  logic [1:0]      sb, sa, sym_valid, frame_start, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_sym [2];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  always #5 clk = ~clk;

  tx_slot_sequencer #(.HOLD_CYCLES(1), .NUM_SLOTS(3)) dut_h1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid[0]), .i_tx_data(tx_data[0]),
    .o_tx_ready(tx_ready[0]), .i_abort(abort[0]), .o_word_out(word_out[0]),
    .o_sb(sb[0]), .o_sa(sa[0]), .o_sym_valid(sym_valid[0]),
    .o_frame_start(frame_start[0]), .o_busy(busy[0])
  );

  tx_slot_sequencer #(.HOLD_CYCLES(4), .NUM_SLOTS(3)) dut_h4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid[1]), .i_tx_data(tx_data[1]),
    .o_tx_ready(tx_ready[1]), .i_abort(abort[1]), .o_word_out(word_out[1]),
    .o_sb(sb[1]), .o_sa(sa[1]), .o_sym_valid(sym_valid[1]),
    .o_frame_start(frame_start[1]), .o_busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected symbol = {frame_start, sB, sA, word_out}
  task automatic push_word(input int d, input logic [5:0] w);
    int hold;
    logic [8:0] e;
    hold = (d == 0) ? 1 : 4;
    for (int s = 0; s < 3; s++) begin
      for (int h = 0; h < hold; h++) begin
        e = {((s == 0) && (h == 0)), 2'(s), w};
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  task automatic mon(input int d);
    logic [8:0] got, exp;
    int sz;
    got = {frame_start[d], sb[d], sa[d], word_out[d]};
    sz  = (d == 0) ? q0.size() : q1.size();
    if (sym_valid[d]) begin
      n_sym[d]++;
      check($sformatf("d%0d_sym_pending", d), 32'(sz != 0), 1);
      if (sz != 0) begin
        exp = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("d%0d_symbol", d), 32'(got), 32'(exp));
      end
    end else begin
      check($sformatf("d%0d_idle_sel", d), {29'd0, frame_start[d], sb[d], sa[d]}, 32'h3);
      check($sformatf("d%0d_gap", d), 32'(sz), 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic send(input int d, input logic [5:0] w);
    int n;
    n = 0;
    tx_valid[d] = 1'b1;
    tx_data[d]  = w;
    forever begin
      @(negedge clk);
      if (tx_ready[d]) break;
      n++;
      if (n > 100) begin
        check("send_timeout", 32'(n), 0);
        tx_valid[d] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    push_word(d, w);
    #1;
    tx_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sym_valid != 2'b00) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_sel"},   {30'd0, sb[d], sa[d]}, 32'h3);
      check({tag, "_flags"}, {29'd0, sym_valid[d], frame_start[d], busy[d]}, 32'h0);
      check({tag, "_word"},  32'(word_out[d]), 0);
    end
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    tx_valid = '0;
    tx_data  = '0;
    abort    = '0;
    n_sym[0] = 0;
    n_sym[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_ready0", 32'(tx_ready[0]), 1);
    check("reset_ready1", 32'(tx_ready[1]), 1);
    @(posedge clk);
    #1;

    base = n_sym[0];
    send(0, 6'b10_01_11);
    drain();
    check("single_len", 32'(n_sym[0] - base), 3);
    check("single_word_held", 32'(word_out[0]), 32'h27);

    base = n_sym[0];
    send(0, 6'h15);
    send(0, 6'h2A);
    drain();
    check("b2b_len", 32'(n_sym[0] - base), 6);

    base = n_sym[0];
    send(0, 6'h0C);
    send(0, 6'h33);
    @(negedge clk);
    check("bp_ready_low", 32'(tx_ready[0]), 0);
    check("bp_busy", 32'(busy[0]), 1);
    send(0, 6'h1E);
    drain();
    check("bp_len", 32'(n_sym[0] - base), 9);

    base = n_sym[1];
    send(1, 6'h2D);
    send(1, 6'h12);
    drain();
    check("hold4_len", 32'(n_sym[1] - base), 24);

    base = n_sym[0];
    send(0, 6'h3C);
    send(0, 6'h0F);
    abort[0]    = 1'b1;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 6'h33;
    @(negedge clk);
    check("abort_ready", 32'(tx_ready[0]), 0);
    @(posedge clk);
    q0.delete();
    #1;
    abort[0]    = 1'b0;
    tx_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_sel", {30'd0, sb[0], sa[0]}, 32'h3);
    check("abort_state", {29'd0, sym_valid[0], busy[0], tx_ready[0]}, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_len", 32'(n_sym[0] - base), 2);

    send(0, 6'h27);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_reset_slot2", {29'd0, sym_valid[0], sb[0], sa[0]}, 32'h6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = n_sym[0];
    send(0, 6'h1B);
    drain();
    check("post_reset_len", 32'(n_sym[0] - base), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
